// File: rtl/dbg_cmd_sequencer.sv
// Debug-link command sequencer: decodes UART command bytes, drives CPU reset and
// clock-enable, snapshots the memory bus and streams responses over valid/ready.
module dbg_cmd_sequencer #(
  parameter int RST_CYCLES  = 4,
  parameter int STEP_GAP    = 4,
  parameter int ARG_TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cpu_rst,
  output logic        cpu_clk_en,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_rdata,
  output logic        busy,
  output logic        overrun
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RST_HOLD = 3'd1;
  localparam logic [2:0] S_GET_ARG  = 3'd2;
  localparam logic [2:0] S_STEP     = 3'd3;
  localparam logic [2:0] S_SEND     = 3'd4;

  localparam logic [7:0] OP_RESET    = 8'h01;
  localparam logic [7:0] OP_STEP     = 8'h02;
  localparam logic [7:0] OP_READ_BUS = 8'h03;

  localparam logic [7:0] RSP_ACK     = 8'hA5;
  localparam logic [7:0] RSP_NAK     = 8'hEE;
  localparam logic [7:0] RSP_TIMEOUT = 8'hEF;

  // One shared cycle counter serves the reset hold, the argument timeout and the
  // step period, so it is sized for the largest of the three.
  localparam int MAX_AB  = (RST_CYCLES > STEP_GAP) ? RST_CYCLES : STEP_GAP;
  localparam int MAX_CNT = (ARG_TIMEOUT > MAX_AB) ? ARG_TIMEOUT : MAX_AB;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(STEP_GAP - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(ARG_TIMEOUT - 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [8:0]    step_cnt;
  logic [63:0]   resp;
  logic [2:0]    resp_last;
  logic [2:0]    idx;

  // NOTE: every register below is assigned with <= so all of them sample the
  // pre-edge values of each other; a blocking = here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      step_cnt  <= '0;
      resp      <= '0;
      resp_last <= '0;
      idx       <= '0;
      overrun   <= 1'b0;
    end else begin
      // Bytes that arrive while the sequencer cannot consume them are dropped.
      if (rx_valid && (state == S_RST_HOLD || state == S_STEP || state == S_SEND))
        overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            cnt <= '0;
            idx <= '0;
            case (rx_data)
              OP_RESET: state <= S_RST_HOLD;
              OP_STEP:  state <= S_GET_ARG;
              OP_READ_BUS: begin
                // Little-endian: address bytes go out first, then read data.
                resp      <= {bus_rdata, bus_addr};
                resp_last <= 3'd7;
                state     <= S_SEND;
              end
              default: begin
                resp      <= {56'h0, RSP_NAK};
                resp_last <= 3'd0;
                state     <= S_SEND;
              end
            endcase
          end
        end

        S_RST_HOLD: begin
          if (cnt == RST_LAST) begin
            cnt       <= '0;
            resp      <= {56'h0, RSP_ACK};
            resp_last <= 3'd0;
            state     <= S_SEND;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_GET_ARG: begin
          if (rx_valid) begin
            step_cnt <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            cnt      <= '0;
            state    <= S_STEP;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt       <= '0;
            resp      <= {56'h0, RSP_TIMEOUT};
            resp_last <= 3'd0;
            state     <= S_SEND;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_STEP: begin
          if (cnt == GAP_LAST) begin
            cnt      <= '0;
            step_cnt <= step_cnt - 9'd1;
            if (step_cnt == 9'd1) begin
              resp      <= {56'h0, RSP_ACK};
              resp_last <= 3'd0;
              state     <= S_SEND;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_SEND: begin
          if (tx_ready) begin
            if (idx == resp_last) begin
              idx   <= '0;
              state <= S_IDLE;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign tx_valid   = (state == S_SEND);
  assign cpu_rst    = (state == S_RST_HOLD);
  assign cpu_clk_en = (state == S_RST_HOLD) || (state == S_STEP && cnt == '0);

  // NOTE: the default assignment first keeps this combinational block free of
  // inferred latches on every path.
  always_comb begin
    tx_data = 8'h00;
    if (state == S_SEND)
      tx_data = resp[{idx, 3'b000} +: 8];
  end

endmodule

// File: doc/dbg_cmd_sequencer.md
# dbg_cmd_sequencer

Byte-level command sequencer for the OTTER debug link. It sits between the UART byte transceiver and the CPU. It decodes single- and two-byte debug commands, then drives the CPU reset and clock-enable. It also snapshots the memory bus and returns responses over a valid/ready byte channel. It replaces bit-serial command handling with a fully synchronous controller on the system clock.

## Interface
Parameters:
- RST_CYCLES, 4: number of cycles `cpu_rst` is held during a RESET command (≥1).
- STEP_GAP, 4: period in cycles between successive `cpu_clk_en` pulses during STEP (≥1).
- ARG_TIMEOUT, 1_000_000: cycles to wait for a STEP argument byte before aborting.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received command byte.
- rx_valid  in  1  one-cycle strobe qualifying `rx_data`; no backpressure.
- tx_data  out  8  response byte.
- tx_valid  out  1  response byte valid.
- tx_ready  in  1  transceiver accepts `tx_data`.
- cpu_rst  out  1  CPU reset.
- cpu_clk_en  out  1  CPU clock-enable; one pulse advances the CPU one cycle.
- bus_addr  in  32  memory bus address.
- bus_rdata  in  32  memory bus read data.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; set when `rx_valid` arrives in a state that does not consume it; cleared only by `rst`.

## Operation
- Reset values:
  - state = IDLE.
  - tx_valid=0, tx_data=0x00.
  - cpu_rst=0, cpu_clk_en=0.
  - busy=0, overrun=0.
  - all counters 0.
- Opcodes, full byte:
  - 0x01 RESET.
  - 0x02 STEP, followed by one argument byte N.
  - 0x03 READ_BUS.
  - Any other value is a NAK.
- Response codes:
  - ACK = 0xA5.
  - NAK = 0xEE.
  - TIMEOUT = 0xEF.
- States and transitions:
  - IDLE: on rx_valid, decode `rx_data` and go to RST_HOLD, GET_ARG, or SEND (READ_BUS, NAK).
  - RST_HOLD: cpu_rst=1 and cpu_clk_en=1 for RST_CYCLES cycles; then SEND with ACK.
  - GET_ARG: on rx_valid, latch step count = (N==0 ? 256 : N), 9-bit; go to STEP. If ARG_TIMEOUT cycles elapse with no byte, go to SEND with TIMEOUT.
  - STEP: cpu_clk_en high in the first cycle of each STEP_GAP-cycle period, low otherwise. Decrement the count once per period. After the final period completes, go to SEND with ACK.
  - SEND: shift out the response buffer one byte per tx handshake; go to IDLE after the last byte.
- READ_BUS:
  - `bus_addr` and `bus_rdata` are sampled on the same edge that accepts the opcode.
  - The response is 8 bytes: addr[7:0], addr[15:8], addr[23:16], addr[31:24], then rdata in the same little-endian order.
- Single-byte responses: ACK, NAK, TIMEOUT.
- Overrun: `rx_valid` in RST_HOLD, STEP, or SEND is dropped and sets `overrun`. In GET_ARG, rx_valid is the argument and does not set overrun.
- `rst` asserted mid-command aborts the command immediately:
  - a partial step count is discarded;
  - an in-flight response is abandoned;
  - cpu_rst and cpu_clk_en drop on the next edge.

## Timing
- Opcode accepted at edge t (rx_valid high in cycle t): the next state is in effect from cycle t+1.
- RESET:
  - cpu_rst and cpu_clk_en are high in cycles t+1 … t+RST_CYCLES.
  - tx_valid rises in cycle t+RST_CYCLES+1.
- STEP:
  - Argument accepted in cycle a.
  - The first pulse is in cycle a+1; pulses are at a+1+k·STEP_GAP for k = 0 … count-1.
  - tx_valid (ACK) rises at a+1+count·STEP_GAP.
- READ_BUS / NAK: tx_valid rises in cycle t+1.
- TX handshake:
  - A byte transfers in any cycle with tx_valid && tx_ready.
  - tx_data and tx_valid hold stable while tx_ready=0.
  - After a transfer, the next byte is presented in the following cycle (tx_valid stays high).
  - After the last transfer, tx_valid=0 and the state is IDLE on the next cycle.
- An opcode can be accepted in the cycle immediately after SEND returns to IDLE. No opcode is accepted in the same cycle as the final transfer.
- The timeout counter starts at 0 on entry to GET_ARG. The abort occurs when the count reaches ARG_TIMEOUT without rx_valid.
- busy is high from cycle t+1 through the cycle of the final tx transfer.

## Test plan
- RESET with tx_ready=1, rst released → send 0x01. Expect cpu_rst and cpu_clk_en high for exactly 4 cycles, then a single 0xA5 one cycle later, then busy=0.
- STEP: send 0x02 then 0x03 with STEP_GAP=4. Expect exactly 3 cpu_clk_en pulses 4 cycles apart, then ACK 0xA5. Repeat with N=0 and expect 256 pulses.
- READ_BUS: bus_addr=0x0000_1004, bus_rdata=0xDEAD_BEEF, tx_ready toggling every other cycle. Expect bytes 04 10 00 00 EF BE AD DE, each held stable until accepted.
- Unknown opcode 0x7F → single 0xEE. Opcode 0x02 with no argument and ARG_TIMEOUT=16 → 0xEF after 16 cycles, then return to IDLE.
- Overrun: send 0x55 during STEP. Expect overrun=1, step count unaffected, overrun held until rst.
- Mid-command reset: assert rst during STEP pulse 2 of 5 and in the middle of the READ_BUS response. Expect all outputs at reset values on the next edge and no further pulses or bytes.
